mips_mc_control: RTL
====================

# mips_mc_control

Multi-cycle control unit for the Harvard MIPS core; successor to the two-state fetch/execute controller. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready handshake to both memories, a parametrised wait timeout, illegal-opcode trapping and a retired-instruction counter. Sits between the instruction register and the datapath; drives PC, register file, ALU and RAM control lines.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- WAIT_TIMEOUT, 16, max wait cycles for mem_ready per request; 0 disables the timeout

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_opcode  in  6  IR[31:26], stable from DECODE onward
- func_code  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  active memory (instr in FETCH, data in MEM) accepts/returns this cycle
- instr_req  out  1  instruction fetch request
- ir_write  out  1  load IR; also PC+4 pulse
- pc_load  out  1  load PC from pc_src
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs
- mem_req, MemRead, MemWrite  out  1 each  data RAM request/direction
- RegDst, ALUSrc, MemtoReg, RegWrite  out  1 each  datapath selects, active high
- ALUOp  out  6  instr_opcode passthrough
- halt  out  1  sticky, core stopped by opcode 0x3F
- err  out  1  sticky, core stopped by fault
- err_code  out  2  1 illegal opcode/funct, 2 memory timeout
- retired  out  CNT_W  count of completed instructions
- state_o  out  3  current state encoding

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5, ERROR=6.
- FETCH: instr_req=1 until mem_ready; on mem_ready ir_write=1 for that cycle -> DECODE.
- DECODE: opcode 0x3F -> HALTED (halt=1). Supported: R-type funct 0x21 ADDU / 0x08 JR, 0x09 ADDIU, 0x23 LW, 0x2B SW, 0x02 J, 0x04 BEQ, 0x05 BNE. Anything else -> ERROR, err_code=1. Else -> EXEC.
- EXEC: ADDU/ADDIU -> WB (ALUSrc=1 for ADDIU). LW/SW: ALUSrc=1 -> MEM. J: pc_load=1, pc_src=2. JR: pc_load=1, pc_src=3. BEQ/BNE: pc_load=alu_zero (BEQ) / !alu_zero (BNE), pc_src=1. Jumps/branches retire -> FETCH.
- MEM: mem_req=1, MemRead=LW, MemWrite=SW, held until mem_ready; LW -> WB, SW retires -> FETCH.
- WB: RegWrite=1 one cycle; RegDst=1 for ADDU; MemtoReg=1 for LW; retires -> FETCH.
- Retire: retired += 1 on the cycle leaving EXEC/MEM/WB to FETCH; wraps modulo 2^CNT_W.
- Timeout: wait counter clears on entering FETCH/MEM and on mem_ready; if it reaches WAIT_TIMEOUT with mem_ready low -> ERROR, err_code=2, request dropped.
- HALTED/ERROR are absorbing until rst_n; all strobes 0 there.
- Any control output not listed for a state is 0.

## Timing
- Reset (async assert, sync-safe deassert): state=FETCH, all outputs 0, retired=0, halt=0, err=0, err_code=0; ALUOp still mirrors instr_opcode.
- First instr_req is asserted in the first cycle after rst_n deasserts.
- Outputs decoded combinationally from registered state + opcode; halt, err, err_code, retired registered.
- Zero-wait memory (mem_ready high on request cycle): ADDU/ADDIU 4 cycles, LW 5, SW 4, J/JR/BEQ/BNE 3; each wait cycle adds 1.
- mem_ready outside FETCH/MEM ignored. mem_ready on the exact timeout cycle wins (transaction completes).
- Reset mid-MEM: mem_req/MemWrite drop asynchronously; the store is not guaranteed.

## Structure
- mips_ctrl_pkg: state enum, opcode/funct localparams, pc_src enum, err_code constants.
- One sub-module: mips_wait_timer (parametrised WAIT_TIMEOUT counter, clear/enable in, expired out); WAIT_TIMEOUT=0 ties expired low.

## Test plan
- ADDU ($1=$2+$3), mem_ready tied high -> states 0,1,2,4; RegWrite=RegDst=1 in cycle 4; retired=1.
- LW, mem_ready low 3 cycles in MEM -> mem_req/MemRead held 4 cycles, then WB with MemtoReg=1; total 8 cycles.
- BEQ alu_zero=1 then BNE alu_zero=1 -> pc_load=1/pc_src=1 for first, pc_load=0 for second; retired=2.
- Fetch with mem_ready stuck low, WAIT_TIMEOUT=4 -> ERROR after 4 wait cycles, err=1, err_code=2, instr_req=0 thereafter.
- Opcode 0x3F -> HALTED, halt=1, retired unchanged; opcode 0x0C -> ERROR, err_code=1.
- rst_n low during SW MEM wait -> all outputs 0 immediately, state=FETCH, retired=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// state machine, PC source select, instruction classes and fault codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;

  typedef enum logic [3:0] {
    I_ADDU, I_JR, I_ADDIU, I_LW, I_SW, I_J, I_BEQ, I_BNE, I_HALT, I_ILLEGAL
  } instr_e;

  typedef struct packed {
    logic    instr_req;
    logic    ir_write;
    logic    pc_load;
    pc_src_e pc_src;
    logic    mem_req;
    logic    mem_read;
    logic    mem_write;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
  } ctrl_t;

  function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] fn);
    instr_e cls;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU)    cls = I_ADDU;
        else if (fn == FN_JR) cls = I_JR;
        else                  cls = I_ILLEGAL;
      end
      OP_ADDIU: cls = I_ADDIU;
      OP_LW:    cls = I_LW;
      OP_SW:    cls = I_SW;
      OP_J:     cls = I_J;
      OP_BEQ:   cls = I_BEQ;
      OP_BNE:   cls = I_BNE;
      OP_HALT:  cls = I_HALT;
      default:  cls = I_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Memory wait-cycle counter; expired is high once WAIT_TIMEOUT wait cycles
// have elapsed since the last clear. WAIT_TIMEOUT=0 keeps expired low.
module mips_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != W'(WAIT_TIMEOUT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // With a zero timeout the counter parks at 0 and this never fires.
  assign expired = (WAIT_TIMEOUT != 0) && (cnt_q == W'(WAIT_TIMEOUT));

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory ready
// handshake, wait timeout, illegal-opcode trap and retired-instruction count.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       instr_opcode,
  input  logic [5:0]       func_code,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             instr_req,
  output logic             ir_write,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [5:0]       ALUOp,
  output logic             halt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  state_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl_c, ctrl;
  instr_e           cls;
  logic             retire;
  logic             wait_en, wait_clr, wait_expired;

  assign cls = decode_instr(instr_opcode, func_code);

  mips_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clr),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  assign wait_en  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wait_clr = mem_ready || (state_d != state_q);

  always_comb begin
    state_d    = state_q;
    ctrl_c     = '0;
    halt_d     = halt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.instr_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          state_d         = S_DECODE;
        end else if (wait_expired) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (cls == I_HALT) begin
          state_d = S_HALTED;
          halt_d  = 1'b1;
        end else if (cls == I_ILLEGAL) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          I_ADDU:  state_d = S_WB;
          I_ADDIU: begin ctrl_c.alu_src = 1'b1; state_d = S_WB;  end
          I_LW,
          I_SW:    begin ctrl_c.alu_src = 1'b1; state_d = S_MEM; end
          I_J: begin
            ctrl_c.pc_load = 1'b1;
            ctrl_c.pc_src  = PC_JUMP;
          end
          I_JR: begin
            ctrl_c.pc_load = 1'b1;
            ctrl_c.pc_src  = PC_RS;
          end
          I_BEQ: begin
            ctrl_c.pc_load = alu_zero;
            ctrl_c.pc_src  = PC_BRANCH;
          end
          I_BNE: begin
            ctrl_c.pc_load = !alu_zero;
            ctrl_c.pc_src  = PC_BRANCH;
          end
          default: ;
        endcase
        if (state_d == S_EXEC) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.mem_read  = (cls == I_LW);
        ctrl_c.mem_write = (cls == I_SW);
        if (mem_ready) begin
          if (cls == I_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_expired) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = (cls == I_ADDU);
        ctrl_c.mem_to_reg = (cls == I_LW);
        state_d           = S_FETCH;
        retire            = 1'b1;
      end
      default: ;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      retired_q  <= retired_d;
    end
  end

  // Strobes are forced low while reset is held so a store in flight drops at once.
  assign ctrl = rst_n ? ctrl_c : '0;

  assign instr_req = ctrl.instr_req;
  assign ir_write  = ctrl.ir_write;
  assign pc_load   = ctrl.pc_load;
  assign pc_src    = ctrl.pc_src;
  assign mem_req   = ctrl.mem_req;
  assign MemRead   = ctrl.mem_read;
  assign MemWrite  = ctrl.mem_write;
  assign RegDst    = ctrl.reg_dst;
  assign ALUSrc    = ctrl.alu_src;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegWrite  = ctrl.reg_write;
  assign ALUOp     = instr_opcode;
  assign halt      = halt_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign retired   = retired_q;
  assign state_o   = state_q;

endmodule
